// File: rtl/spike_pkg.sv
// Shared widths, sample rate and event-word layout for the spike event packer.
// Event word: {seq, ts}, sequence number in the upper byte.
package spike_pkg;

   localparam int TS_W           = 24;
   localparam int SEQ_W          = 8;
   localparam int EVT_W          = 32;
   localparam int SAMPLE_RATE_HZ = 2000;
   localparam int DROP_CNT_W     = 16;

   localparam int EVT_TS_LSB  = 0;
   localparam int EVT_TS_MSB  = TS_W - 1;
   localparam int EVT_SEQ_LSB = TS_W;
   localparam int EVT_SEQ_MSB = TS_W + SEQ_W - 1;

   typedef struct packed {
      logic [SEQ_W-1:0] seq;
      logic [TS_W-1:0]  ts;
   } evt_word_t;

   function automatic logic [EVT_W-1:0] pack_evt(input logic [SEQ_W-1:0] seq,
                                                 input logic [TS_W-1:0]  ts);
      evt_word_t w;
      w.seq = seq;
      w.ts  = ts;
      return w;
   endfunction

endpackage

// File: rtl/spike_evt_fifo.sv
// Synchronous first-word-fall-through buffer; the head entry is visible on o_data
// whenever the buffer is non-empty, and o_data reads zero when empty.
module spike_evt_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_level == '0);
   assign o_full    = (r_level == (AW+1)'(DEPTH));
   assign o_level   = r_level;
   assign w_do_pop  = i_pop && !o_empty;
   // When full, a same-cycle pop frees the slot the write lands in.
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

   // NOTE: storage is deliberately not reset; level and pointers alone decide validity.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/spike_event_packer.sv
// Timestamps spike pulses into {seq, ts} event words and buffers them for a valid/ready consumer.
// Optional macro SPIKE_EVT_DROP_CNT_EN adds a saturating drop_count output.
module spike_event_packer
   import spike_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        spike_detected,
   input  logic                        evt_ready,
   input  logic                        ovf_clr,
   output logic                        evt_valid,
   output logic [EVT_W-1:0]            evt_data,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef SPIKE_EVT_DROP_CNT_EN
   ,
   output logic [DROP_CNT_W-1:0]       drop_count
`endif
);

   logic [TS_W-1:0]  r_ts;
   logic [SEQ_W-1:0] r_seq;
   logic             r_overflow;
   logic             w_spike;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   logic             w_full;
   logic             w_empty;

   assign w_spike = spike_detected && !rst;
   assign w_pop   = evt_valid && evt_ready;
   assign w_push  = w_spike && (!w_full || w_pop);
   assign w_drop  = w_spike && w_full && !w_pop;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ts  <= '0;
         r_seq <= '0;
      end else begin
         r_ts <= r_ts + 1'b1;
         if (spike_detected) r_seq <= r_seq + 1'b1;
      end
   end

   // A drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst)          r_overflow <= 1'b0;
      else if (w_drop)  r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
   end

   assign overflow = r_overflow;

`ifdef SPIKE_EVT_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] r_drop_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_drop_cnt <= '0;
      end else if (w_drop) begin
         if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
      end else if (ovf_clr) begin
         r_drop_cnt <= '0;
      end
   end

   assign drop_count = r_drop_cnt;
`endif

   spike_evt_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (pack_evt(r_seq, r_ts)),
      .i_pop   (w_pop),
      .o_data  (evt_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (fifo_level)
   );

   assign evt_valid = !w_empty;

endmodule

// File: tb/tb_spike_event_packer.sv
// Directed bench for spike_event_packer (FIFO_DEPTH = 8); inputs change and outputs
// are sampled on the falling clock edge.
module tb_spike_event_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        spike_detected = 1'b0;
   logic        evt_ready = 1'b0;
   logic        ovf_clr = 1'b0;
   logic        evt_valid;
   logic [31:0] evt_data;
   logic        overflow;
   logic [3:0]  fifo_level;
`ifdef SPIKE_EVT_DROP_CNT_EN
   logic [15:0] drop_count;
`endif

   int n_cmp = 0;
   int n_err = 0;

   spike_event_packer #(.FIFO_DEPTH(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .spike_detected (spike_detected),
      .evt_ready      (evt_ready),
      .ovf_clr        (ovf_clr),
      .evt_valid      (evt_valid),
      .evt_data       (evt_data),
      .overflow       (overflow),
      .fifo_level     (fifo_level)
`ifdef SPIKE_EVT_DROP_CNT_EN
      ,
      .drop_count     (drop_count)
`endif
   );

   always #5 clk = ~clk;

   // Applies one reset edge and returns on the falling edge that starts cycle 0.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; spike_detected = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; spike_detected = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", evt_valid); end
      n_cmp++; if (evt_data !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h want 00000000", evt_data); end
      n_cmp++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", overflow); end
`ifdef SPIKE_EVT_DROP_CNT_EN
      n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL rst_drops: got %0d want 0", drop_count); end
`endif
      rst = 1'b0; spike_detected = 1'b0;
   endtask

   task automatic test_single_event();
      evt_ready = 1'b1;
      repeat (10) @(negedge clk);
      spike_detected = 1'b1;
      @(negedge clk);
      spike_detected = 1'b0;
      n_cmp++; if (evt_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", evt_valid); end
      n_cmp++; if (evt_data !== 32'h0000000A) begin n_err++; $display("FAIL single_data: got %h want 0000000a", evt_data); end
      @(negedge clk);
      n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL single_gone: got %b want 0", evt_valid); end
      n_cmp++; if (evt_data !== 32'h0) begin n_err++; $display("FAIL single_empty_data: got %h want 00000000", evt_data); end
      evt_ready = 1'b0;
   endtask

   task automatic test_overflow();
      logic [31:0] exp;
      do_reset();
      spike_detected = 1'b1;
      repeat (9) @(negedge clk);
      spike_detected = 1'b0;
      n_cmp++; if (fifo_level !== 4'd8) begin n_err++; $display("FAIL ovf_level: got %0d want 8", fifo_level); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
      n_cmp++; if (evt_data !== 32'h0) begin n_err++; $display("FAIL ovf_head: got %h want 00000000", evt_data); end
`ifdef SPIKE_EVT_DROP_CNT_EN
      n_cmp++; if (drop_count !== 16'd1) begin n_err++; $display("FAIL ovf_drops: got %0d want 1", drop_count); end
`endif
      @(negedge clk);
      n_cmp++; if (evt_valid !== 1'b1 || evt_data !== 32'h0) begin
         n_err++; $display("FAIL ovf_hold: got valid=%b data=%h want 1/00000000", evt_valid, evt_data);
      end
      evt_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp = {8'(i), 24'(i)};
         n_cmp++; if (evt_valid !== 1'b1 || evt_data !== exp) begin
            n_err++; $display("FAIL drain_%0d: got valid=%b data=%h want 1/%h", i, evt_valid, evt_data, exp);
         end
         @(negedge clk);
      end
      evt_ready = 1'b0;
      n_cmp++; if (evt_valid !== 1'b0 || fifo_level !== 4'd0) begin
         n_err++; $display("FAIL drain_empty: got valid=%b level=%0d want 0/0", evt_valid, fifo_level);
      end
      spike_detected = 1'b1;
      @(negedge clk);
      spike_detected = 1'b0;
      n_cmp++; if (evt_data[31:24] !== 8'd9) begin n_err++; $display("FAIL gap_seq: got %0d want 9", evt_data[31:24]); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
   endtask

   task automatic test_ovf_clr();
      spike_detected = 1'b1;
      repeat (8) @(negedge clk);
      n_cmp++; if (fifo_level !== 4'd8) begin n_err++; $display("FAIL clr_fill: got %0d want 8", fifo_level); end
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0; spike_detected = 1'b0;
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL clr_set_wins: got %b want 1", overflow); end
      n_cmp++; if (fifo_level !== 4'd8 || evt_data[31:24] !== 8'd10) begin
         n_err++; $display("FAIL clr_unchanged: got level=%0d seq=%0d want 8/10", fifo_level, evt_data[31:24]);
      end
`ifdef SPIKE_EVT_DROP_CNT_EN
      n_cmp++; if (drop_count !== 16'd2) begin n_err++; $display("FAIL clr_drops_inc: got %0d want 2", drop_count); end
`endif
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clr_alone: got %b want 0", overflow); end
`ifdef SPIKE_EVT_DROP_CNT_EN
      n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL clr_drops_zero: got %0d want 0", drop_count); end
`endif
   endtask

   task automatic test_full_pop();
      logic [31:0] exp;
      do_reset();
      spike_detected = 1'b1;
      repeat (8) @(negedge clk);
      evt_ready = 1'b1;
      @(negedge clk);
      spike_detected = 1'b0; evt_ready = 1'b0;
      n_cmp++; if (fifo_level !== 4'd8) begin n_err++; $display("FAIL fullpop_level: got %0d want 8", fifo_level); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_ovf: got %b want 0", overflow); end
      evt_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         exp = {8'(i), 24'(i)};
         n_cmp++; if (evt_data !== exp) begin n_err++; $display("FAIL fullpop_drain_%0d: got %h want %h", i, evt_data, exp); end
         @(negedge clk);
      end
      evt_ready = 1'b0;
      n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL fullpop_empty: got %b want 0", evt_valid); end
   endtask

   task automatic test_ts_wrap();
      do_reset();
      force dut.r_ts = 24'hFFFFFE;
      #1 release dut.r_ts;
      @(negedge clk);
      spike_detected = 1'b1;
      repeat (2) @(negedge clk);
      spike_detected = 1'b0;
      n_cmp++; if (fifo_level !== 4'd2) begin n_err++; $display("FAIL wrap_level: got %0d want 2", fifo_level); end
      n_cmp++; if (evt_data !== 32'h00FFFFFF) begin n_err++; $display("FAIL wrap_first: got %h want 00ffffff", evt_data); end
      evt_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (evt_data !== 32'h01000000) begin n_err++; $display("FAIL wrap_second: got %h want 01000000", evt_data); end
      @(negedge clk);
      evt_ready = 1'b0;
   endtask

   task automatic test_reset_flush();
      do_reset();
      spike_detected = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (fifo_level !== 4'd3) begin n_err++; $display("FAIL flush_fill: got %0d want 3", fifo_level); end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (evt_valid !== 1'b0 || fifo_level !== 4'd0 || evt_data !== 32'h0) begin
         n_err++; $display("FAIL flush_cleared: got valid=%b level=%0d data=%h want 0/0/00000000", evt_valid, fifo_level, evt_data);
      end
      rst = 1'b0; spike_detected = 1'b0;
      repeat (4) @(negedge clk);
      spike_detected = 1'b1;
      @(negedge clk);
      spike_detected = 1'b0;
      n_cmp++; if (evt_data !== 32'h00000004) begin n_err++; $display("FAIL flush_next: got %h want 00000004", evt_data); end
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_event();
      test_overflow();
      test_ovf_clr();
      test_full_pop();
      test_ts_wrap();
      test_reset_flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
